spram_frame_reader: RTL and testbench

- Read-side master for the single-port SPRAM frame buffer. The camera capture path writes pixels into this buffer; this block reads them back.
- Sequentially fetches FRAME_WORDS 16-bit pixels per frame, starting from address 0, and delivers them to the VGA pixel pipeline over a valid/ready stream.
- Yields the RAM port to the write side whenever grant is low.
- Holds a small prefetch FIFO to hide SPRAM read latency and arbitration gaps.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/spram_frame_reader_pix_fifo.sv | 74 +++++++
 rtl/spram_frame_reader.sv | 143 ++++++++++++++
 tb/tb_spram_frame_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared constants and types for the SPRAM frame-buffer
//                read path.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int unsigned FB_ADDR_W = 14;
    localparam int unsigned FB_DATA_W = 16;
    localparam int unsigned FB_MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef logic [FB_DATA_W-1:0] pix_t;

endpackage

`default_nettype wire

// File: rtl/spram_frame_reader_pix_fifo.sv
// ============================================================================
//  Module      : pix_fifo
//  Description : Small synchronous FIFO with flush, occupancy output and the
//                head word visible on data_o (zero while empty).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pix_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH[AW:0]);
    assign do_pop  = pop_i && !empty;
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_push = push_i && (!full || do_pop);

    assign empty_o = empty;
    assign count_o = count_q;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/spram_frame_reader.sv
// ============================================================================
//  Module      : spram_frame_reader
//  Description : Read-side master for the SPRAM frame buffer. Fetches
//                FRAME_WORDS pixels from address 0 through a credit-limited
//                prefetch FIFO and streams them out over valid/ready.
//                Optional macro SPRAM_READER_UNDERRUN_CNT_EN adds a
//                saturating underrun cycle counter on port underrun_cnt.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module spram_frame_reader
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 16384,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 start,
    input  logic                 grant,
    output logic [FB_ADDR_W-1:0] ram_ad,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [FB_MASK_W-1:0] ram_maskwe,
    input  logic [FB_DATA_W-1:0] ram_do,
    output pix_t                 pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 busy,
`ifdef SPRAM_READER_UNDERRUN_CNT_EN
    output logic                 frame_done,
    output logic [15:0]          underrun_cnt
`else
    output logic                 frame_done
`endif
);

    localparam int unsigned          CW        = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]          DEPTH_C   = FIFO_DEPTH[CW:0];
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FRAME_WORDS - 1);

    rd_state_t            state_q;
    logic [FB_ADDR_W-1:0] addr_q;
    logic                 inflight_q;
    logic                 frame_done_q;

    logic [CW:0] fifo_count;
    logic [CW:0] pending;
    logic        fifo_empty;
    logic        issue;
    logic        pop;
    logic        push;
    logic        done_cond;

    // Words already buffered plus the one possibly on its way back from the RAM.
    assign pending = fifo_count + {{CW{1'b0}}, inflight_q};

    // A restart cycle never issues: anything fetched then would be thrown away.
    assign issue = (state_q == RUN) && grant && !start && (pending < DEPTH_C);
    assign pop   = pix_valid && pix_ready;
    // Read data returning on a restart cycle belongs to the aborted frame.
    assign push  = inflight_q && !start;

    // Last pixel leaves the FIFO this cycle (or already has) with nothing pending.
    assign done_cond = (state_q == DRAIN) && !inflight_q &&
                       ((fifo_count == '0) ||
                        ((fifo_count == {{CW{1'b0}}, 1'b1}) && pop));

    assign ram_ad     = addr_q;
    assign ram_cs     = issue;
    assign ram_we     = 1'b0;
    assign ram_maskwe = '0;
    assign pix_valid  = !fifo_empty;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

    // Frame sequencing: address generation, in-flight tracking and done pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            inflight_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= done_cond;
            inflight_q   <= issue;
            if (start) begin
                state_q <= RUN;
                addr_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: addr_q <= '0;
                    RUN: begin
                        if (issue) begin
                            addr_q <= addr_q + FB_ADDR_W'(1);
                            if (addr_q == LAST_ADDR) state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (done_cond) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FB_DATA_W)
    ) u_pix_fifo (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .flush_i     (start),
        .push_i      (push),
        .push_data_i (ram_do),
        .pop_i       (pop),
        .data_o      (pix_data),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifdef SPRAM_READER_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    // Count cycles where the consumer is waiting on an empty FIFO mid-frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            underrun_q <= '0;
        end else if (start) begin
            underrun_q <= '0;
        end else if (busy && pix_ready && !pix_valid && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spram_frame_reader.sv
// ============================================================================
//  Module      : tb_spram_frame_reader
//  Description : Self-checking bench for spram_frame_reader with an SPRAM
//                model (data = address + 16'hA000) and a pixel scoreboard.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spram_frame_reader;

    localparam int unsigned FW = 8;
    localparam int unsigned FD = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        start;
    logic        grant;
    logic [13:0] ram_ad;
    logic        ram_cs;
    logic        ram_we;
    logic [3:0]  ram_maskwe;
    logic [15:0] ram_do;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        frame_done;
`ifdef SPRAM_READER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int          exp_addr     = 0;
    int          reads_issued = 0;
    int          hs_cnt       = 0;
    logic        exp_done     = 1'b0;
    logic        done_seen    = 1'b0;

    always #5 CLK = ~CLK;

    spram_frame_reader #(
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .start      (start),
        .grant      (grant),
        .ram_ad     (ram_ad),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_maskwe (ram_maskwe),
        .ram_do     (ram_do),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .busy       (busy),
`ifdef SPRAM_READER_UNDERRUN_CNT_EN
        .frame_done (frame_done),
        .underrun_cnt (underrun_cnt)
`else
        .frame_done (frame_done)
`endif
    );

    // SPRAM model: one-cycle read latency, poison value when not selected.
    always @(posedge CLK) begin
        ram_do <= ram_cs ? (16'hA000 + {2'b00, ram_ad}) : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            exp_q.delete();
            exp_addr     = 0;
            reads_issued = 0;
            exp_done     = 1'b0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            if (frame_done) done_seen = 1'b1;
            exp_done = 1'b0;
            if (ram_cs) begin
                chk("ram_ad", 32'(ram_ad), 32'(exp_addr));
                chk("cs_with_grant", 32'(grant), 32'd1);
                exp_addr++;
                reads_issued++;
            end
            if (pix_valid && pix_ready) begin : b_pop
                logic [15:0] e;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("pix_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", 32'(pix_data), 32'(e));
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end
            end
            if (start) begin
                exp_q.delete();
                for (int i = 0; i < FW; i++) exp_q.push_back(16'hA000 + 16'(i));
                exp_addr     = 0;
                reads_issued = 0;
                hs_cnt       = 0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        done_seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!done_seen && n < maxc) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done_seen), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_hs(input int target, input int maxc);
        int n;
        n = 0;
        while (hs_cnt < target && n < maxc) begin
            tick();
            n++;
        end
        chk("hs_reached", 32'(hs_cnt), 32'(target));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_cs"},    32'(ram_cs),    32'd0);
        chk({tag, "_ram_ad"},    32'(ram_ad),    32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_data"},  32'(pix_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(frame_done), 32'd0);
        chk({tag, "_we"},        32'(ram_we),    32'd0);
        chk({tag, "_mask"},      32'(ram_maskwe), 32'd0);
    endtask

    initial begin
        RESET_N   = 1'b0;
        start     = 1'b0;
        grant     = 1'b1;
        pix_ready = 1'b1;
        repeat (2) tick();
        chk_all_zero("reset");
        RESET_N = 1'b1;
        tick();

        // Straight frame, free-running grant and ready.
        pulse_start();
        wait_done(100);

        // Consumer stalled: prefetch stops at FIFO depth, then drains in order.
        pix_ready = 1'b0;
        pulse_start();
        repeat (10) tick();
        chk("reads_ready_low", 32'(reads_issued), 32'(FD));
        chk("valid_ready_low", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        wait_done(100);

        // Grant pattern 1,0,0,1 repeating.
        pulse_start();
        for (int c = 0; c < 200 && !done_seen; c++) begin
            grant = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
        end
        grant = 1'b1;
        wait_done(50);

        // Restart while the FIFO still holds pixels of the first frame.
        pulse_start();
        wait_hs(2, 50);
        pix_ready = 1'b0;
        repeat (8) tick();
        chk("valid_before_restart", 32'(pix_valid), 32'd1);
        pulse_start();
        chk("valid_after_restart", 32'(pix_valid), 32'd0);
        pix_ready = 1'b1;
        wait_done(100);

        // Asynchronous reset mid-frame, then a clean frame from address 0.
        pulse_start();
        repeat (4) tick();
        chk("busy_mid_frame", 32'(busy), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        pulse_start();
        wait_done(100);

`ifdef SPRAM_READER_UNDERRUN_CNT_EN
        // Consumer ready but RAM withheld for 10 cycles.
        grant = 1'b0;
        pix_ready = 1'b1;
        pulse_start();
        repeat (10) tick();
        chk("underrun_about_10", 32'((underrun_cnt >= 16'd9) && (underrun_cnt <= 16'd11)), 32'd1);
        grant = 1'b1;
        wait_done(100);
        pulse_start();
        chk("underrun_cleared", 32'(underrun_cnt), 32'd0);
        wait_done(100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
